// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host receiver with Set-2 scan code decoding.
// Produces per-action key-state words for the keyboard memory window.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        key_clear,
    output logic [15:0] forward,
    output logic [15:0] backward,
    output logic [15:0] turnleft,
    output logic [15:0] turnright,
    output logic [15:0] shoot,
    output logic [15:0] escape,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt_clk;
    logic [FW-1:0] flt_cnt;
    logic          fall;

    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          par;
    logic [TW-1:0] tcnt;

    logic ext_pending, break_pending;
    logic fwd_r, bwd_r, left_r, right_r, shoot_r, esc_r;

    // Idle PS/2 lines are high, so the synchronizers come out of reset at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_clk <= 1'b1;
            flt_cnt  <= '0;
        end else if (clk_s2 == filt_clk) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s2;
            flt_cnt  <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    assign fall = filt_clk & ~clk_s2 & (flt_cnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            par       <= 1'b0;
            tcnt      <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE || fall) tcnt <= '0;
            else                       tcnt <= tcnt + 1'b1;
            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= data_s2;
                        state <= STOP;
                    end
                    default: begin
                        if (data_s2 && (^{shreg, par})) begin
                            rx_byte  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                tcnt      <= '0;
            end
        end
    end

    // A later set of shoot/escape overrides key_clear, so a press is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_pending   <= 1'b0;
            break_pending <= 1'b0;
            fwd_r         <= 1'b0;
            bwd_r         <= 1'b0;
            left_r        <= 1'b0;
            right_r       <= 1'b0;
            shoot_r       <= 1'b0;
            esc_r         <= 1'b0;
        end else begin
            if (key_clear) begin
                shoot_r <= 1'b0;
                esc_r   <= 1'b0;
            end
            if (frame_err) begin
                ext_pending   <= 1'b0;
                break_pending <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == 8'hE0) begin
                    ext_pending <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    break_pending <= 1'b1;
                end else begin
                    ext_pending   <= 1'b0;
                    break_pending <= 1'b0;
                    if (ext_pending) begin
                        case (rx_byte)
                            8'h75:   fwd_r   <= ~break_pending;
                            8'h72:   bwd_r   <= ~break_pending;
                            8'h6B:   left_r  <= ~break_pending;
                            8'h74:   right_r <= ~break_pending;
                            default: ;
                        endcase
                    end else begin
                        case (rx_byte)
                            8'h1D:   fwd_r   <= ~break_pending;
                            8'h1B:   bwd_r   <= ~break_pending;
                            8'h1C:   left_r  <= ~break_pending;
                            8'h23:   right_r <= ~break_pending;
                            8'h29:   if (!break_pending) shoot_r <= 1'b1;
                            8'h76:   if (!break_pending) esc_r <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign forward   = {15'd0, fwd_r};
    assign backward  = {15'd0, bwd_r};
    assign turnleft  = {15'd0, left_r};
    assign turnright = {15'd0, right_r};
    assign shoot     = {15'd0, shoot_r};
    assign escape    = {15'd0, esc_r};

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of scan-code frames
// plus hand-written sequences for timeout, clear race, glitch and reset.
module tb_ps2_key_decoder;

    localparam int H    = 20;
    localparam int TOUT = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        key_clear;
    logic [15:0] forward, backward, turnleft, turnright, shoot, escape;
    logic [7:0]  rx_byte;
    logic        rx_valid, frame_err;

    logic clear_on_valid = 1'b0;
    logic lone_clear = 1'b0;
    assign key_clear = (clear_on_valid & rx_valid) | lone_clear;

    ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_clear(key_clear), .forward(forward), .backward(backward),
        .turnleft(turnleft), .turnright(turnright), .shoot(shoot),
        .escape(escape), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int nv = 0, ne = 0, nboth = 0;

    always @(posedge clk) begin
        if (rx_valid) nv++;
        if (frame_err) ne++;
        if (rx_valid && frame_err) nboth++;
    end

    typedef struct {
        logic [7:0] code;
        bit         bad;
        logic [5:0] keys;
        int         v;
        int         e;
    } vec_t;

    vec_t vt[23];

    function automatic logic [5:0] keys();
        return {forward[0], backward[0], turnleft[0],
                turnright[0], shoot[0], escape[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (H) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    int v0, e0;

    initial begin
        vt[0]  = '{8'h1D, 1'b0, 6'b100000, 1, 0};
        vt[1]  = '{8'hF0, 1'b0, 6'b100000, 1, 0};
        vt[2]  = '{8'h1D, 1'b0, 6'b000000, 1, 0};
        vt[3]  = '{8'hE0, 1'b0, 6'b000000, 1, 0};
        vt[4]  = '{8'h6B, 1'b0, 6'b001000, 1, 0};
        vt[5]  = '{8'hE0, 1'b0, 6'b001000, 1, 0};
        vt[6]  = '{8'hF0, 1'b0, 6'b001000, 1, 0};
        vt[7]  = '{8'h6B, 1'b0, 6'b000000, 1, 0};
        vt[8]  = '{8'h6B, 1'b0, 6'b000000, 1, 0};
        vt[9]  = '{8'h29, 1'b1, 6'b000000, 0, 1};
        vt[10] = '{8'h29, 1'b0, 6'b000010, 1, 0};
        vt[11] = '{8'h1B, 1'b0, 6'b010010, 1, 0};
        vt[12] = '{8'h1B, 1'b0, 6'b010010, 1, 0};
        vt[13] = '{8'hE0, 1'b0, 6'b010010, 1, 0};
        vt[14] = '{8'h1D, 1'b0, 6'b010010, 1, 0};
        vt[15] = '{8'h74, 1'b0, 6'b010010, 1, 0};
        vt[16] = '{8'hE0, 1'b0, 6'b010010, 1, 0};
        vt[17] = '{8'h74, 1'b0, 6'b010110, 1, 0};
        vt[18] = '{8'hF0, 1'b0, 6'b010110, 1, 0};
        vt[19] = '{8'h1B, 1'b0, 6'b000110, 1, 0};
        vt[20] = '{8'hF0, 1'b0, 6'b000110, 1, 0};
        vt[21] = '{8'h29, 1'b0, 6'b000110, 1, 0};
        vt[22] = '{8'hF0, 1'b0, 6'b000110, 1, 0};

        repeat (3) @(negedge clk);
        check("reset_keys", {16'd0, keys()}, 32'd0);
        check("reset_rx", {23'd0, rx_byte, rx_valid}, 32'd0);
        check("reset_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 23; i++) begin
            v0 = nv;
            e0 = ne;
            send_frame(vt[i].code, vt[i].bad, 11);
            check($sformatf("vec%0d_valid", i), nv - v0, vt[i].v);
            check($sformatf("vec%0d_err", i), ne - e0, vt[i].e);
            check($sformatf("vec%0d_keys", i), {26'd0, keys()}, {26'd0, vt[i].keys});
            if (vt[i].v == 1)
                check($sformatf("vec%0d_byte", i), {24'd0, rx_byte}, {24'd0, vt[i].code});
        end
        check("upper_bits", {forward[15:1], backward[15:1], turnleft[15:1],
                             turnright[15:1]} == 60'd0, 32'd1);

        // Break prefix pending (vt[22]), then a frame stalls mid-way.
        v0 = nv;
        e0 = ne;
        send_frame(8'h76, 1'b0, 5);
        repeat (TOUT + 100) @(negedge clk);
        check("tout_err", ne - e0, 1);
        check("tout_valid", nv - v0, 0);
        send_frame(8'h76, 1'b0, 11);
        check("tout_next_keys", {26'd0, keys()}, {26'd0, 6'b000111});
        check("tout_next_byte", {24'd0, rx_byte}, 32'h76);

        // key_clear in the same cycle as an escape make.
        clear_on_valid = 1'b1;
        send_frame(8'h76, 1'b0, 11);
        clear_on_valid = 1'b0;
        check("clr_race_keys", {26'd0, keys()}, {26'd0, 6'b000101});
        lone_clear = 1'b1;
        @(negedge clk);
        lone_clear = 1'b0;
        repeat (2) @(negedge clk);
        check("lone_clear_keys", {26'd0, keys()}, {26'd0, 6'b000100});

        // Short low glitch on ps2_clk while idle.
        v0 = nv;
        e0 = ne;
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_err", ne - e0, 0);
        check("glitch_valid", nv - v0, 0);

        // Reset while a frame is in DATA.
        send_frame(8'h1C, 1'b0, 4);
        reset = 1'b1;
        #1;
        check("mid_reset_keys", {26'd0, keys()}, 32'd0);
        check("mid_reset_rx", {23'd0, rx_byte, rx_valid}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        v0 = nv;
        e0 = ne;
        send_frame(8'h1D, 1'b0, 11);
        check("post_reset_valid", nv - v0, 1);
        check("post_reset_err", ne - e0, 0);
        check("post_reset_byte", {24'd0, rx_byte}, 32'h1D);
        check("post_reset_keys", {26'd0, keys()}, {26'd0, 6'b100000});

        check("valid_err_exclusive", nboth, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream neighbour of the memory controller's keyboard window: receives raw PS/2 device-to-host frames from the board pins.
- Decodes Set-2 scan codes (make, E0 extended, F0 break) into per-action key-state words.
- The memory controller exposes those words to the CPU as memory-mapped reads and drives key_clear.
- Replaces the ad-hoc keyboard logic; single 50 MHz domain.

Parameters:
- FILTER_LEN, 8, consecutive identical synchronized ps2_clk samples required to accept a new level (glitch filter).
- TIMEOUT_CYCLES, 100000, clk cycles without a falling edge mid-frame before the frame is aborted (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock (CLK_50MHZ).
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- key_clear  in  1  one-cycle strobe from the memory controller; clears the sticky shoot/escape flags.
- forward  out  16  bit0 = forward held (W or E0 75); bits 15:1 = 0.
- backward  out  16  bit0 = backward held (S or E0 72).
- turnleft  out  16  bit0 = left held (A or E0 6B).
- turnright  out  16  bit0 = right held (D or E0 74).
- shoot  out  16  bit0 = sticky, space (29) pressed since last clear.
- escape  out  16  bit0 = sticky, Esc (76) pressed since last clear.
- rx_byte  out  8  last correctly received byte.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Reset (async, active-high): all outputs 0, FSM to IDLE, prefix flags cleared, filter state = 1, timeout counter = 0.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - The filtered clock changes only after FILTER_LEN consecutive equal samples.
  - A falling edge is a filtered 1->0 transition; ps2_data (synchronized) is sampled in that cycle.
- Frame FSM (advances only on falling edges):
  - IDLE: data=0 -> DATA with bit count 0. Data=1 -> stay in IDLE, pulse frame_err.
  - DATA: shift 8 bits LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: if stop=1 and odd parity over data+parity holds -> rx_byte <= byte and rx_valid pulses the following cycle. Otherwise frame_err pulses. Either way -> IDLE.
- Timeout: in any state other than IDLE, the counter increments every clk and resets on each falling edge. Reaching TIMEOUT_CYCLES -> IDLE, frame_err pulse, prefix flags cleared.
- Decoder (acts in the cycle rx_valid is high; key outputs are visible the next cycle):
  - E0: set ext_pending.
  - F0: set break_pending.
  - Any other byte: look up (ext_pending, byte).
    - Movement key: set on make, clear on break.
    - Shoot/escape: set on make, ignore on break.
    - Unmapped codes: no change.
    - Both prefix flags clear after any non-prefix byte.
  - E0 with W/S/A/D codes is unmapped. Non-E0 75/72/6B/74 (keypad) is unmapped.
- Any frame_err clears both prefix flags, so a following byte is never treated as a break.
- key_clear clears shoot and escape. If key_clear coincides with a shoot/escape make in the same cycle, set wins (event not lost).
- Typematic repeats (repeated make) leave the outputs unchanged.
- rx_valid and frame_err are never both high.

Test Plan:
- Send frame 0x1D (W make) at an 80 µs PS/2 clock period -> rx_byte=0x1D, rx_valid pulses once, forward=16'h0001. Then send F0,1D -> forward=0.
- Send E0,6B -> turnleft=1. Send E0,F0,6B -> turnleft=0. Send 6B alone -> turnleft unchanged.
- Send 0x29 with bad parity -> frame_err pulse, no rx_valid, shoot=0. A following valid 0x29 -> shoot=1.
- Send F0, then stop clocking mid-frame after 4 bits for >100000 cycles -> frame_err, FSM in IDLE. Next frame 0x76 -> escape=1 (treated as make, not break).
- escape=1, assert key_clear in the same cycle the decoder processes a 0x76 make -> escape stays 1. A lone key_clear -> escape=0.
- Inject a 5-cycle low glitch on ps2_clk in IDLE -> no edge, no frame_err. Assert reset mid-DATA -> all outputs 0; the next full frame decodes correctly.
